// File: rtl/adpll_ring_sequencer_if.sv
// Shared configuration write port of the ADPLL ring.
// The sequencer (master) presents one node/word pair with we held high
// until the slave returns ack; only one write is outstanding at a time.
//   node : target DCO node index
//   word : bias/control word for that node
//   we   : write request, held stable with node/word until ack
//   ack  : write accepted; a write completes on any cycle where we and ack are both high
interface adpll_ring_sequencer_if #(
  parameter int NUM_NODES = 4,
  parameter int CW_WIDTH  = 12
);
  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic [NODE_W-1:0]   node;
  logic [CW_WIDTH-1:0] word;
  logic                we;
  logic                ack;

  modport master (output node, output word, output we, input ack);
  modport slave  (input node, input word, input we, output ack);
endinterface

// File: rtl/adpll_ring_sequencer.sv
// Start-up and lock sequencer for the 2x2 ADPLL ring.
// Nodes are brought up one at a time in index order: write the bias word,
// wait a settle interval, then qualify lock from the node's phase error on
// reference edges. A node that times out is retried with a stepped bias;
// after MAX_RETRIES failed retries the sequence stops in FAIL.
// Ports:
//   clk100_i, rst_pbn_i        : 100 MHz clock, asynchronous active-low reset
//   start_i                    : level; its rising edge launches a sequence from IDLE/DONE/FAIL
//   bias_override_en_i/_i      : optional switch-supplied initial bias
//   ref_edge_i                 : one-cycle pulse per reference edge (already synchronised)
//   phase_err_i                : packed signed phase error, node k at [k*ERR_WIDTH +: ERR_WIDTH]
//   cfg                        : configuration write port (master side)
//   node_en_o, locked_o        : per-node enable and lock flags
//   busy_o, done_o, fail_o     : sequence status
//   fail_node_o                : node that exhausted its retries
module adpll_ring_sequencer #(
  parameter int NUM_NODES     = 4,
  parameter int CW_WIDTH      = 12,
  parameter int BIAS_DEFAULT  = 154,
  parameter int BIAS_STEP     = 8,
  parameter int ERR_WIDTH     = 8,
  parameter int ERR_WINDOW    = 4,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_COUNT    = 16,
  parameter int TIMEOUT_EDGES = 256,
  parameter int MAX_RETRIES   = 3,
  localparam int NODE_W       = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                           clk100_i,
  input  logic                           rst_pbn_i,
  input  logic                           start_i,
  input  logic                           bias_override_en_i,
  input  logic [CW_WIDTH-1:0]            bias_override_i,
  input  logic                           ref_edge_i,
  input  logic [NUM_NODES*ERR_WIDTH-1:0] phase_err_i,
  adpll_ring_sequencer_if.master         cfg,
  output logic [NUM_NODES-1:0]           node_en_o,
  output logic [NUM_NODES-1:0]           locked_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           fail_o,
  output logic [NODE_W-1:0]              fail_node_o
);

  localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOCK_W  = $clog2(LOCK_COUNT + 1);
  localparam int EDGE_W  = $clog2(TIMEOUT_EDGES + 1);
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NUM_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_SETTLE, S_CHECK, S_RETRY, S_NEXT, S_DONE, S_FAIL
  } state_t;

  // |e| computed one bit wider so the most negative code maps to +2^(ERR_WIDTH-1).
  function automatic logic [ERR_WIDTH:0] abs_err(input logic signed [ERR_WIDTH-1:0] e);
    logic signed [ERR_WIDTH:0] ext;
    ext = {e[ERR_WIDTH-1], e};
    return (ext < 0) ? -ext : ext;
  endfunction

  // Bias increment, saturating at the all-ones control word.
  function automatic logic [CW_WIDTH-1:0] bias_step_sat(input logic [CW_WIDTH-1:0] b);
    logic [CW_WIDTH:0] sum;
    sum = {1'b0, b} + (CW_WIDTH+1)'(BIAS_STEP);
    return sum[CW_WIDTH] ? {CW_WIDTH{1'b1}} : sum[CW_WIDTH-1:0];
  endfunction

  state_t                 state;
  logic                   start_q;
  logic [CW_WIDTH-1:0]    init_bias;
  logic [CW_WIDTH-1:0]    bias;
  logic [NODE_W-1:0]      idx;
  logic [RETRY_W-1:0]     retry_cnt;
  logic [SET_W-1:0]       settle_cnt;
  logic [LOCK_W-1:0]      lock_cnt;
  logic [EDGE_W-1:0]      edge_cnt;

  logic                   launch;
  logic [CW_WIDTH-1:0]    launch_bias;
  logic signed [ERR_WIDTH-1:0] err_sel;
  logic                   in_window;
  logic [LOCK_W-1:0]      lock_next;
  logic [EDGE_W-1:0]      edge_next;

  always_comb begin
    launch      = start_i && !start_q &&
                  (state == S_IDLE || state == S_DONE || state == S_FAIL);
    launch_bias = bias_override_en_i ? bias_override_i : CW_WIDTH'(BIAS_DEFAULT);
    err_sel     = phase_err_i[int'(idx)*ERR_WIDTH +: ERR_WIDTH];
    in_window   = (abs_err(err_sel) <= (ERR_WIDTH+1)'(ERR_WINDOW));
    lock_next   = in_window ? lock_cnt + 1'b1 : '0;
    edge_next   = edge_cnt + 1'b1;
  end

  always_ff @(posedge clk100_i or negedge rst_pbn_i) begin
    if (!rst_pbn_i) begin
      state       <= S_IDLE;
      start_q     <= 1'b0;
      init_bias   <= '0;
      bias        <= '0;
      idx         <= '0;
      retry_cnt   <= '0;
      settle_cnt  <= '0;
      lock_cnt    <= '0;
      edge_cnt    <= '0;
      cfg.node    <= '0;
      cfg.word    <= '0;
      cfg.we      <= 1'b0;
      node_en_o   <= '0;
      locked_o    <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      fail_o      <= 1'b0;
      fail_node_o <= '0;
    end else begin
      start_q <= start_i;
      if (launch) begin
        init_bias   <= launch_bias;
        bias        <= launch_bias;
        idx         <= '0;
        retry_cnt   <= '0;
        node_en_o   <= '0;
        locked_o    <= '0;
        done_o      <= 1'b0;
        fail_o      <= 1'b0;
        fail_node_o <= '0;
        busy_o      <= 1'b1;
        state       <= S_CFG;
      end else begin
        case (state)
          // Config write: raise the request once, then hold until acked.
          S_CFG: begin
            if (!cfg.we) begin
              cfg.we         <= 1'b1;
              cfg.node       <= idx;
              cfg.word       <= bias;
              node_en_o[idx] <= 1'b1;
            end else if (cfg.ack) begin
              cfg.we     <= 1'b0;
              settle_cnt <= '0;
              state      <= S_SETTLE;
            end
          end
          // Settle interval after the write.
          S_SETTLE: begin
            if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
              lock_cnt <= '0;
              edge_cnt <= '0;
              state    <= S_CHECK;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          // Lock qualification on reference edges; lock beats timeout on the same edge.
          S_CHECK: begin
            if (ref_edge_i) begin
              lock_cnt <= lock_next;
              edge_cnt <= edge_next;
              if (lock_next == LOCK_W'(LOCK_COUNT)) begin
                locked_o[idx] <= 1'b1;
                state         <= S_NEXT;
              end else if (edge_next == EDGE_W'(TIMEOUT_EDGES)) begin
                state <= S_RETRY;
              end
            end
          end
          S_RETRY: begin
            if (retry_cnt == RETRY_W'(MAX_RETRIES)) begin
              fail_o         <= 1'b1;
              fail_node_o    <= idx;
              node_en_o[idx] <= 1'b0;
              busy_o         <= 1'b0;
              state          <= S_FAIL;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              bias      <= bias_step_sat(bias);
              state     <= S_CFG;
            end
          end
          S_NEXT: begin
            if (idx == LAST_NODE) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= S_DONE;
            end else begin
              idx       <= idx + 1'b1;
              retry_cnt <= '0;
              bias      <= init_bias;
              state     <= S_CFG;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adpll_ring_sequencer.sv
// Directed bench for adpll_ring_sequencer: a table of full start-up runs
// (per-node error patterns and expected write log / final status) plus
// hand-written sequences for lock-counter restart and reset mid-write.
module tb_adpll_ring_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ov_en = 1'b0;
  logic [11:0] ov = '0;
  logic        ref_edge;
  logic [31:0] phase_err;
  logic [3:0]  node_en, locked;
  logic        busy, done, fail;
  logic [1:0]  fail_node;

  adpll_ring_sequencer_if #(.NUM_NODES(4), .CW_WIDTH(12)) cfg();

  adpll_ring_sequencer dut (
    .clk100_i(clk), .rst_pbn_i(rst_n), .start_i(start),
    .bias_override_en_i(ov_en), .bias_override_i(ov),
    .ref_edge_i(ref_edge), .phase_err_i(phase_err), .cfg(cfg),
    .node_en_o(node_en), .locked_o(locked), .busy_o(busy),
    .done_o(done), .fail_o(fail), .fail_node_o(fail_node)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            ov_en;
    logic [11:0]     ov;
    logic [3:0][2:0] bad_n;    // number of leading attempts per node with bad error
    logic [3:0][7:0] bad_val;  // error driven during those attempts
    int              n_wr;
    logic [7:0][13:0] wr;      // expected {node, word} write log
    logic            done;
    logic            fail;
    logic [1:0]      fnode;
    logic [3:0]      locked;
    logic [3:0]      node_en;
  } vec_t;

  vec_t vecs[6];

  int n_cmp = 0;
  int n_bad = 0;

  logic [13:0] wr_q[$];
  int          base = 0;
  int          cyc = 0;
  logic        manual = 1'b0;
  logic        man_ref = 1'b0;
  logic [7:0]  man_err = '0;
  logic        auto_ref = 1'b0;
  logic [31:0] auto_err = '0;
  logic [3:0][2:0] cur_bad_n = '0;
  logic [3:0][7:0] cur_bad_val = '0;
  logic        ack_en = 1'b0;
  logic        ack_r = 1'b0;

  assign ref_edge  = manual ? man_ref : auto_ref;
  assign phase_err = manual ? {24'd0, man_err} : auto_err;
  assign cfg.ack   = ack_en & ack_r;

  // Completed writes are logged on the clock edge that completes them.
  always @(posedge clk)
    if (rst_n && cfg.we && cfg.ack) wr_q.push_back({cfg.node, cfg.word});

  // Reference edge every 4 cycles; each node's error depends on how many
  // writes it has received since the current run started.
  always @(negedge clk) begin
    cyc++;
    auto_ref = (cyc % 4 == 0);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      for (int j = base; j < wr_q.size(); j++)
        if (int'(wr_q[j][13:12]) == k) n++;
      auto_err[k*8 +: 8] = (n <= int'(cur_bad_n[k])) ? cur_bad_val[k] : 8'd0;
    end
    ack_r = cfg.we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic oe, input logic [11:0] o,
                         input logic [3:0][2:0] bn, input logic [3:0][7:0] bv,
                         input logic d, input logic f, input logic [1:0] fn,
                         input logic [3:0] lk, input logic [3:0] en);
    vecs[i].ov_en = oe; vecs[i].ov = o; vecs[i].bad_n = bn; vecs[i].bad_val = bv;
    vecs[i].n_wr = 0; vecs[i].wr = '0; vecs[i].done = d; vecs[i].fail = f;
    vecs[i].fnode = fn; vecs[i].locked = lk; vecs[i].node_en = en;
  endtask

  task automatic add_wr(input int i, input logic [1:0] node, input logic [11:0] word);
    vecs[i].wr[vecs[i].n_wr] = {node, word};
    vecs[i].n_wr++;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    bit fin;
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    manual = 1'b0; ack_en = 1'b1;
    ov_en = v.ov_en; ov = v.ov;
    cur_bad_n = v.bad_n; cur_bad_val = v.bad_val;
    base = wr_q.size();
    pulse_start();
    repeat (200) @(negedge clk);
    pulse_start();  // arrives while busy: must be ignored
    fin = 1'b0;
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      if (done || fail) begin fin = 1'b1; break; end
    end
    chk($sformatf("v%0d_finished", i), 32'(fin), 32'd1);
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_n_writes", i), 32'(wr_q.size() - base), 32'(v.n_wr));
    for (int j = 0; j < v.n_wr; j++)
      chk($sformatf("v%0d_write%0d", i, j),
          (base + j < wr_q.size()) ? 32'(wr_q[base + j]) : 32'hFFFF_FFFF, 32'(v.wr[j]));
    chk($sformatf("v%0d_done", i), 32'(done), 32'(v.done));
    chk($sformatf("v%0d_fail", i), 32'(fail), 32'(v.fail));
    chk($sformatf("v%0d_fail_node", i), 32'(fail_node), 32'(v.fnode));
    chk($sformatf("v%0d_locked", i), 32'(locked), 32'(v.locked));
    chk($sformatf("v%0d_node_en", i), 32'(node_en), 32'(v.node_en));
    chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
    chk($sformatf("v%0d_we", i), 32'(cfg.we), 32'd0);
  endtask

  task automatic man_edge(input logic [7:0] e);
    @(negedge clk) man_ref = 1'b1; man_err = e;
    @(negedge clk) man_ref = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 32'(cfg.we), 32'd0);
    chk({tag, "_node"}, 32'(cfg.node), 32'd0);
    chk({tag, "_word"}, 32'(cfg.word), 32'd0);
    chk({tag, "_status"}, {24'd0, busy, done, fail, fail_node, 3'd0}, 32'd0);
    chk({tag, "_en_lock"}, {24'd0, node_en, locked}, 32'd0);
  endtask

  initial begin
    bit got;
    // Vector table: {override, error pattern} -> expected write log and status.
    set_vec(0, 0, 12'd0, '0, '0, 1, 0, 2'd0, 4'hF, 4'hF);
    for (int n = 0; n < 4; n++) add_wr(0, 2'(n), 12'd154);
    set_vec(1, 1, 12'd80, '0, '0, 1, 0, 2'd0, 4'hF, 4'hF);
    for (int n = 0; n < 4; n++) add_wr(1, 2'(n), 12'd80);
    set_vec(2, 0, 12'd0, {3'd1, 3'd1, 3'd0, 3'd0}, {8'h80, 8'd9, 8'd0, 8'd0},
            1, 0, 2'd0, 4'hF, 4'hF);
    add_wr(2, 0, 154); add_wr(2, 1, 154); add_wr(2, 2, 154); add_wr(2, 2, 162);
    add_wr(2, 3, 154); add_wr(2, 3, 162);
    set_vec(3, 0, 12'd0, {3'd0, 3'd0, 3'd4, 3'd0}, {8'd0, 8'd0, 8'd20, 8'd0},
            0, 1, 2'd1, 4'b0001, 4'b0001);
    add_wr(3, 0, 154); add_wr(3, 1, 154); add_wr(3, 1, 162); add_wr(3, 1, 170);
    add_wr(3, 1, 178);
    set_vec(4, 1, 12'd4090, {3'd0, 3'd0, 3'd0, 3'd4}, {8'd0, 8'd0, 8'd0, 8'd20},
            0, 1, 2'd0, 4'b0000, 4'b0000);
    add_wr(4, 0, 4090); add_wr(4, 0, 4095); add_wr(4, 0, 4095); add_wr(4, 0, 4095);
    vecs[5] = vecs[0];

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("after_reset");

    for (int i = 0; i < 6; i++) run_vec(i);

    // Lock-counter restart: 15 in-window edges, one at |err|=5, then a fresh 16 needed.
    @(negedge clk);
    ov_en = 1'b0; ack_en = 1'b1; manual = 1'b1; man_ref = 1'b0; man_err = '0;
    base = wr_q.size();
    pulse_start();
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_q.size() > base) begin got = 1'b1; break; end
    end
    chk("restart_first_write", 32'(got), 32'd1);
    repeat (1100) @(negedge clk);
    for (int e = 0; e < 15; e++) man_edge(8'd4);
    man_edge(8'd5);
    for (int e = 0; e < 15; e++) man_edge(8'hFC);
    chk("restart_not_locked_31", 32'(locked), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    man_edge(8'd0);
    chk("restart_locked_32", 32'(locked), 32'd1);
    manual = 1'b0;

    // Write held unacked for 50 cycles, then reset mid-write.
    @(negedge clk);
    ack_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    base = wr_q.size();
    pulse_start();
    chk("hold_we_early", 32'(cfg.we), 32'd1);
    repeat (50) @(negedge clk);
    chk("hold_we", 32'(cfg.we), 32'd1);
    chk("hold_node_word", {18'd0, cfg.node, cfg.word}, {18'd0, 2'd0, 12'd154});
    chk("hold_busy_en", {28'd0, busy, 3'd0} | 32'(node_en), 32'h9);
    chk("hold_no_write", 32'(wr_q.size() - base), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk) rst_n = 1'b1;
    ack_en = 1'b1;
    base = wr_q.size();
    pulse_start();
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_q.size() > base) begin got = 1'b1; break; end
    end
    chk("rerun_write_seen", 32'(got), 32'd1);
    chk("rerun_write0", got ? 32'(wr_q[base]) : 32'hFFFF_FFFF, 32'({2'd0, 12'd154}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_ring_sequencer.md
Name: adpll_ring_sequencer

Overview:
- Start-up and lock sequencer for the 2x2 ADPLL ring.
- Brings the NUM_NODES DCO nodes up one at a time over a single shared configuration write port.
- For each node: writes the bias/control word, waits a settle interval, then qualifies lock from the node's phase error sampled on reference edges.
- Retries a failing node with a stepped bias; raises done or fail to the board-level top (LEDs/switch logic).

Parameters:
- NUM_NODES, 4, number of ring nodes sequenced in index order 0..NUM_NODES-1
- CW_WIDTH, 12, control/bias word width
- BIAS_DEFAULT, 154, initial bias word for every node
- BIAS_STEP, 8, bias increment applied per retry
- ERR_WIDTH, 8, signed phase-error width per node
- ERR_WINDOW, 4, lock tolerance: |err| <= ERR_WINDOW
- SETTLE_CYCLES, 1024, clk100 cycles to wait after a config write
- LOCK_COUNT, 16, consecutive in-window reference edges required for lock
- TIMEOUT_EDGES, 256, reference edges allowed in CHECK before a retry
- MAX_RETRIES, 3, retries per node before fail

Ports:
- clk100_i, in, 1, 100 MHz system clock
- rst_pbn_i, in, 1, asynchronous active-low reset
- start_i, in, 1, level; rising edge (registered) launches a sequence from IDLE, DONE or FAIL
- bias_override_en_i, in, 1, when 1, use bias_override_i as the initial bias instead of BIAS_DEFAULT
- bias_override_i, in, CW_WIDTH, switch-supplied initial bias
- ref_edge_i, in, 1, one-cycle pulse per reference edge, already synchronised to clk100_i
- phase_err_i, in, NUM_NODES*ERR_WIDTH, signed error per node; node k occupies bits [k*ERR_WIDTH +: ERR_WIDTH]
- cfg_node_o, out, $clog2(NUM_NODES), target node of the write
- cfg_word_o, out, CW_WIDTH, control word to write
- cfg_we_o, out, 1, write request
- cfg_ack_i, in, 1, write accepted
- node_en_o, out, NUM_NODES, per-node enable
- locked_o, out, NUM_NODES, per-node lock flags
- busy_o, out, 1, sequence in progress
- done_o, out, 1, all nodes locked
- fail_o, out, 1, a node exhausted its retries
- fail_node_o, out, $clog2(NUM_NODES), index of the failing node

Behaviour:
- Reset values: all outputs 0; state IDLE; node index 0; retry count 0.
- States: IDLE, CFG, SETTLE, CHECK, RETRY, NEXT, DONE, FAIL.
- IDLE:
  - On start edge: bias <= override_en ? bias_override_i : BIAS_DEFAULT.
  - Clear locked_o, node_en_o, done_o and fail_o.
  - Node index 0, retry count 0. Go to CFG.
- CFG:
  - Drive cfg_we_o=1, cfg_node_o=index, cfg_word_o=bias; set node_en_o[index]=1.
  - Hold all three outputs stable until cfg_ack_i=1.
  - Ack in the same cycle as the request completes the write.
  - The cycle after ack: cfg_we_o=0, settle counter cleared, go to SETTLE.
  - Only one write is ever outstanding.
- SETTLE: count SETTLE_CYCLES clk100 cycles, then go to CHECK with the lock and edge counters cleared.
- CHECK, evaluated only on cycles with ref_edge_i=1:
  - Edge counter increments on every edge.
  - If |err[index]| <= ERR_WINDOW, the lock counter increments; otherwise the lock counter is cleared.
  - Absolute value is computed at ERR_WIDTH+1 bits, so -2^(ERR_WIDTH-1) is handled correctly.
  - When the lock counter reaches LOCK_COUNT: locked_o[index]=1, go to NEXT.
  - Otherwise, when the edge counter reaches TIMEOUT_EDGES, go to RETRY.
  - If both conditions occur on the same edge, lock wins.
- RETRY:
  - If retry count == MAX_RETRIES: fail_o=1, fail_node_o=index, node_en_o[index]=0, go to FAIL.
  - Else: retry count++, bias <= bias + BIAS_STEP saturating at 2^CW_WIDTH-1, go to CFG.
- NEXT:
  - If index == NUM_NODES-1: done_o=1, go to DONE.
  - Else: index++, retry count 0, bias <= initial bias, go to CFG.
- DONE and FAIL:
  - Outputs held.
  - A new start edge behaves exactly as from IDLE.
- busy_o=1 in every state except IDLE, DONE and FAIL.
- A start edge while busy is ignored.
- Asynchronous reset mid-sequence, including a write in flight: everything returns to reset values immediately, and cfg_we_o drops without waiting for ack.
- Previously locked nodes stay locked_o=1; lock is not re-monitored after qualification.

Test Plan:
1. Reset, start with override off; ack in 1 cycle; err=0 for all nodes. Expect four writes (node 0..3, word 154), each followed by 1024 settle cycles and 16 edges; then done_o=1, locked_o=4'hF, busy_o=0.
2. bias_override_en_i=1, bias_override_i=80. Expect every cfg_word_o to equal 80; the same completion as scenario 1.
3. Node 2 err=+9 for 256 edges, then 0. Expect one retry: writes to node 2 with 154 then 162, then completion. Also drive err=-128 and confirm it is treated as out of window.
4. Node 1 err always 20. Expect words 154, 162, 170, 178 to node 1; then fail_o=1, fail_node_o=1, locked_o=4'b0001, node_en_o[1]=0.
5. Lock-counter restart: err alternates 0 for 15 edges, then 5 for 1 edge, then 0. Expect lock only after a further 16 edges. Separately, override bias 4090 with retries: expect the word to saturate at 4095.
6. Hold cfg_ack_i low for 50 cycles, then assert rst_pbn_i low mid-write. Expect cfg_we_o, busy_o and all other outputs to go to 0 asynchronously; a new start restarts at node 0.
